// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary (Stein) GCD engine.
//   gcd_state_t      : engine FSM state encoding
//   gcd_latency_max  : worst-case accept-to-valid latency for a given operand width
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } gcd_state_t;

    // Upper bound on cycles from the accept edge to the first valid output cycle.
    function automatic int unsigned gcd_latency_max(input int unsigned width);
        return 4 * width + 3;
    endfunction

endpackage

// File: rtl/gcd_stein_if.sv
// Request/result handshake bundle for gcd_stein.
//   master : producer/consumer side (drives request, out_ready_i)
//   slave  : engine side (drives in_ready_o and the result)
interface gcd_stein_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TAG_WIDTH = 4
);
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [TAG_WIDTH-1:0] tag_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [WIDTH-1:0]     gcd_o;
    logic [TAG_WIDTH-1:0] tag_o;
    logic                 coprime_o;

    modport master (
        output in_valid_i, a_i, b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, gcd_o, tag_o, coprime_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, gcd_o, tag_o, coprime_o
    );
endinterface

// File: rtl/gcd_stein_step.sv
// One combinational Stein iteration step.
//   a, b, k     : current operands and common power-of-two count
//   phase       : STRIP or REDUCE (any other value holds the operands)
//   a_nxt/b_nxt/k_nxt : updated values
//   done        : STRIP -> common factor stripped, move to REDUCE
//                 REDUCE -> operands equal, result is valid
//   result      : a << k, meaningful only when REDUCE reports done
module gcd_stein_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    input  gcd_state_t       phase,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = '0;
        if (phase == STRIP) begin
            // Pull out the shared power of two, remembered in k.
            if (!a[0] && !b[0]) begin
                a_nxt = a >> 1;
                b_nxt = b >> 1;
                k_nxt = k + KW'(1);
            end else begin
                done = 1'b1;
            end
        end else if (phase == REDUCE) begin
            // At most one operand is even here; odd-odd differences are even,
            // so a shift always follows a subtraction.
            if (!a[0]) begin
                a_nxt = a >> 1;
            end else if (!b[0]) begin
                b_nxt = b >> 1;
            end else if (a == b) begin
                done   = 1'b1;
                result = a << k;
            end else if (a > b) begin
                a_nxt = a - b;
            end else begin
                b_nxt = b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine, one operation in flight, ready/valid on both sides.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset
//   bus     : request (in_valid_i/in_ready_o/a_i/b_i/tag_i) and
//             result (out_valid_o/out_ready_i/gcd_o/tag_o/coprime_o)
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    gcd_stein_if.slave  bus
);

    localparam int unsigned KW      = $clog2(WIDTH) + 1;
    localparam int unsigned LAT_MAX = gcd_latency_max(WIDTH);
    localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1) + 1;

    gcd_state_t           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic [KW-1:0]        k_q, k_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
    logic [WIDTH-1:0]     gcd_q, gcd_d;
    logic                 coprime_q, coprime_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 load_out;

    logic [WIDTH-1:0]     step_a, step_b, step_result;
    logic [KW-1:0]        step_k;
    logic                 step_done;

    gcd_stein_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .phase  (state_q),
        .a_nxt  (step_a),
        .b_nxt  (step_b),
        .k_nxt  (step_k),
        .done   (step_done),
        .result (step_result)
    );

    // Handshake flags depend on state only; no out_ready_i -> in_ready_o path.
    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.gcd_o       = gcd_q;
    assign bus.tag_o       = tag_out_q;
    assign bus.coprime_o   = coprime_q;

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        result_d  = result_q;
        tag_d     = tag_q;
        gcd_d     = gcd_q;
        tag_out_d = tag_out_q;
        coprime_d = coprime_q;
        lat_d     = lat_q;
        load_out  = 1'b0;
        case (state_q)
            IDLE: begin
                lat_d = '0;
                if (bus.in_valid_i) begin
                    a_d   = bus.a_i;
                    b_d   = bus.b_i;
                    tag_d = bus.tag_i;
                    k_d   = '0;
                    lat_d = LAT_W'(1);
                    if (bus.a_i == '0 || bus.b_i == '0) begin
                        result_d = bus.a_i | bus.b_i;
                        state_d  = DONE;
                        load_out = 1'b1;
                    end else begin
                        state_d = STRIP;
                    end
                end
            end
            STRIP, REDUCE: begin
                a_d = step_a;
                b_d = step_b;
                k_d = step_k;
                if (lat_q != '1) begin
                    lat_d = lat_q + LAT_W'(1);
                end
                if (step_done) begin
                    if (state_q == STRIP) begin
                        state_d = REDUCE;
                    end else begin
                        result_d = step_result;
                        state_d  = DONE;
                        load_out = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Result registers change only when a new result is produced.
        if (load_out) begin
            gcd_d     = result_d;
            tag_out_d = tag_d;
            coprime_d = (result_d == WIDTH'(1));
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            result_q  <= '0;
            tag_q     <= '0;
            gcd_q     <= '0;
            tag_out_q <= '0;
            coprime_q <= 1'b0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            result_q  <= result_d;
            tag_q     <= tag_d;
            gcd_q     <= gcd_d;
            tag_out_q <= tag_out_d;
            coprime_q <= coprime_d;
            lat_q     <= lat_d;
        end
    end

    // Accept-to-valid latency stays within the analytic bound.
    a_latency_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        lat_q <= LAT_W'(LAT_MAX));

    // Shift count never exceeds WIDTH-1.
    a_k_bound: assert property (@(posedge clk_i) disable iff (reset_i)
        k_q <= KW'(WIDTH - 1));

endmodule

// File: doc/gcd_stein.md
Name: gcd_stein

Overview:
- Parametrised binary (Stein) GCD engine with ready/valid handshakes on both input and output.
- Replaces subtract-only Euclid iteration with shift/subtract steps, giving a bounded worst-case latency.
- Carries a per-request tag through the engine and flags coprime operands.
- Sits between a request producer and a result consumer that may apply backpressure; one operation is in flight at a time.

Parameters:
- WIDTH, 8: operand and result width in bits, at least 2.
- TAG_WIDTH, 4: width of the request tag passed through unchanged, at least 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  engine can accept a request.
- a_i  in  WIDTH  operand A, unsigned.
- b_i  in  WIDTH  operand B, unsigned.
- tag_i  in  TAG_WIDTH  request tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- gcd_o  out  WIDTH  gcd(A,B).
- tag_o  out  TAG_WIDTH  tag of the request that produced gcd_o.
- coprime_o  out  1  1 when gcd_o equals 1.

Behaviour:
- Reset (async assert, clocked release):
  - state goes to IDLE.
  - Internal a, b, k and result regs go to 0.
  - out_valid_o=0, gcd_o=0, tag_o=0, coprime_o=0; in_ready_o=1 while in IDLE.
  - Assertion mid-operation abandons the operation. No output is produced for it.
- Shared package enum gcd_state_t has four states: IDLE, STRIP, REDUCE, DONE.
- IDLE:
  - in_ready_o=1.
  - Accept occurs when in_valid_i && in_ready_o. On accept, latch a=a_i, b=b_i, tag, and set k=0.
  - If a_i==0 or b_i==0: result=a_i|b_i, go to DONE.
  - Otherwise go to STRIP.
- STRIP, one step per cycle:
  - If a and b are both even: shift both right by 1, k++.
  - Else go to REDUCE.
- REDUCE, one action per cycle, first matching rule wins:
  - a even: a>>=1.
  - b even: b>>=1.
  - a==b: result=a<<k, go to DONE.
  - a>b: a=a-b.
  - Otherwise: b=b-a.
  - Subtractions never underflow. The final result fits in WIDTH because it divides the original operands.
- k width is $clog2(WIDTH)+1 bits and never exceeds WIDTH-1.
- DONE:
  - out_valid_o=1; gcd_o=result; tag_o=latched tag; coprime_o=(result==1).
  - in_ready_o=0.
  - On out_ready_i=1, go to IDLE next cycle; out_valid_o drops.
  - While out_ready_i=0, gcd_o, tag_o and coprime_o hold stable.
- gcd_o, tag_o and coprime_o are registered and hold their last value after a handshake until the next result.
- in_ready_o is decoded from state only. There is no combinational path from out_ready_i to in_ready_o, so a new request is accepted no earlier than the cycle after the result handshake.
- in_valid_i while not ready is ignored. The request is neither latched nor dropped silently, because the producer must hold it.
- Latency is counted from the accept edge to the first cycle with out_valid_o high:
  - zero operand: exactly 1 cycle.
  - nonzero operands: at most 4*WIDTH+3 cycles.
- Throughput: one result per (latency + 1) cycles at best.
- gcd(0,0)=0, coprime_o=0.

Decomposition:
- gcd_pkg holds:
  - gcd_state_t.
  - function gcd_latency_max(width) returning 4*width+3, used by RTL assertions and the bench.
- Sub-module gcd_stein_step, purely combinational:
  - Inputs: a, b, k, phase (STRIP or REDUCE).
  - Outputs: next a, b and k, plus done and result.
- gcd_stein holds the FSM, handshakes, tag register and output registers.

Test Plan:
- a=12, b=18, tag=3; out_ready_i=1 -> gcd_o=6, tag_o=3, coprime_o=0, latency within bound.
- a=17, b=5 -> gcd_o=1, coprime_o=1.
- a=0, b=9 -> gcd_o=9, out_valid_o exactly 1 cycle after accept. Then a=0, b=0 -> gcd_o=0, coprime_o=0.
- WIDTH=8: a=128, b=192 -> gcd_o=64 (k=6). a=255, b=255 -> gcd_o=255.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o rises -> gcd_o, tag_o and coprime_o stable; in_ready_o=0. A second request offered meanwhile is accepted only the cycle after the handshake and yields its own correct result.
- Reset mid-REDUCE for a=200, b=75 -> out_valid_o=0 and gcd_o=0 immediately, no result emitted. After release, in_ready_o=1, and a=200, b=75 then yields 25.
